// File: rtl/dp_sequencer.sv
// Instruction sequencer: FIFO-buffered 16-bit instructions issued to the datapath
// as a FETCH / READ / WRITE (/ FIN on batch end) sequence.
module dp_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   instr_in,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic [2:0]    src1,
  output logic [2:0]    src2,
  output logic [2:0]    dest,
  output logic [3:0]    opcode,
  output logic          WR,
  output logic          DONE
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [15:0]   ir_reg;
  logic          push, pop;
  logic          reserved_unused;

  // Full is judged on the registered count only, so a pop never frees a slot
  // in the same cycle and there is no path from instr_valid to instr_ready.
  assign instr_ready = (count_reg != CW'(DEPTH));
  assign push        = instr_valid && instr_ready;
  assign pop         = (state_reg == FETCH);

  always_comb begin
    count_next = count_reg + CW'(push) - CW'(pop);
  end

  // Storage has no reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= instr_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ir_reg     <= '0;
      state_reg  <= IDLE;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        ir_reg     <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (count_reg != '0) state_next = FETCH;
      FETCH: state_next = READ;
      READ:  state_next = WRITE;
      // Leaving WRITE looks at the post-edge count so a word arriving now
      // keeps the pipeline streaming at one instruction per three cycles.
      WRITE: begin
        if (ir_reg[0])               state_next = FIN;
        else if (count_next != '0)   state_next = FETCH;
        else                         state_next = IDLE;
      end
      FIN:   state_next = (count_reg != '0) ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state_reg != IDLE);
  assign WR     = (state_reg == WRITE);
  assign DONE   = (state_reg == FIN);
  assign count  = count_reg;
  assign opcode = ir_reg[15:12];
  assign dest   = ir_reg[11:9];
  assign src1   = ir_reg[8:6];
  assign src2   = ir_reg[5:3];

  assign reserved_unused = ^ir_reg[2:1];

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: vector table, scoreboard of issued
// instructions, and hand-written streaming / reset / wrap sequences.
module tb_dp_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   instr_in = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [CW-1:0] count;
  logic          busy;
  logic [2:0]    src1, src2, dest;
  logic [3:0]    opcode;
  logic          WR, DONE;

  dp_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .count(count), .busy(busy),
    .src1(src1), .src2(src2), .dest(dest), .opcode(opcode),
    .WR(WR), .DONE(DONE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [2:0] d;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       last;
    int         exp_cyc;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  op;
    logic [2:0]  d;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic        last;
  } vec_t;

  exp_t exp_q[$];
  int   wr_times[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_pulses = 0;
  int   max_count = 0;
  bit   saw_full = 1'b0;
  bit   expect_done = 1'b0;
  exp_t mon_e;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every WR pulse must match the oldest accepted word.
  always @(negedge clk) begin
    if (rst) begin
      check("count_bound", int'(count <= CW'(DEPTH)), 1);
      check("ready_vs_count", int'(instr_ready), int'(count != CW'(DEPTH)));
      check("done_timing", int'(DONE), int'(expect_done));
      if (DONE) done_pulses++;
      if (int'(count) > max_count) max_count = int'(count);
      if (!instr_ready) saw_full = 1'b1;
      expect_done = 1'b0;
      if (WR) begin
        wr_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("spurious_wr", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_opcode", int'(opcode), int'(mon_e.op));
          check("wr_dest",   int'(dest),   int'(mon_e.d));
          check("wr_src1",   int'(src1),   int'(mon_e.s1));
          check("wr_src2",   int'(src2),   int'(mon_e.s2));
          if (mon_e.exp_cyc >= 0) check("wr_cycle", cyc, mon_e.exp_cyc);
          expect_done = mon_e.last;
          $display("issue cyc=%0d op=%0h dest=%0d src1=%0d src2=%0d last=%0d",
                   cyc, opcode, dest, src1, src2, mon_e.last);
        end
      end
    end else begin
      expect_done = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || count != '0) && g < 200) begin
      step();
      g++;
    end
    check("idle_timeout", int'(g < 200), 1);
    check("sb_drained", exp_q.size(), 0);
  endtask

  // Pushes n words (fields derived from the index), optional random idle gaps.
  task automatic send_batch(input int n, input int last_at, input int op_base,
                            input int max_gap, output int sent);
    int guard = 0;
    int k = 0;
    bit acc;
    exp_t e;
    while (k < n && guard < 400) begin
      e.op = 4'((op_base + k) & 15);
      e.d  = 3'((k + 1) & 7);
      e.s1 = 3'(k & 7);
      e.s2 = 3'((7 - k) & 7);
      e.last = (k == last_at);
      e.exp_cyc = -1;
      instr_in = {e.op, e.d, e.s1, e.s2, 2'b00, e.last};
      instr_valid = 1'b1;
      acc = instr_ready;
      step();
      guard++;
      if (acc) begin
        exp_q.push_back(e);
        k++;
        if (max_gap > 0) begin
          instr_valid = 1'b0;
          repeat ($urandom_range(0, max_gap)) step();
        end
      end
    end
    instr_valid = 1'b0;
    sent = k;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int c0, sent, d0, wn, g;
    vecs[0] = '{16'h1651, 4'h1, 3'd3, 3'd1, 3'd2, 1'b1};
    vecs[1] = '{16'h0000, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0};
    vecs[2] = '{16'hFFFF, 4'hF, 3'd7, 3'd7, 3'd7, 1'b1};
    vecs[3] = '{16'hA4D6, 4'hA, 3'd2, 3'd3, 3'd2, 1'b0};
    vecs[4] = '{16'h3E07, 4'h3, 3'd7, 3'd0, 3'd0, 1'b1};

    // Reset state
    rst = 1'b0;
    repeat (3) step();
    check("rst_wr", int'(WR), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    check("rst_ready", int'(instr_ready), 1);
    check("rst_fields", int'({opcode, dest, src1, src2}), 0);
    rst = 1'b1;
    step();

    // Single-instruction vectors with exact timing from the accept edge
    foreach (vecs[i]) begin
      wait_idle();
      instr_in = vecs[i].instr;
      instr_valid = 1'b1;
      check("vec_ready", int'(instr_ready), 1);
      step();
      instr_valid = 1'b0;
      c0 = cyc;
      exp_q.push_back('{vecs[i].op, vecs[i].d, vecs[i].s1, vecs[i].s2, vecs[i].last, c0 + 3});
      step();
      check("vec_busy_fetch", int'(busy), 1);
      step(); step();
      check("vec_wr_e3", int'(WR), 1);
      check("vec_dest_e3", int'(dest), int'(vecs[i].d));
      step();
      check("vec_wr_e4", int'(WR), 0);
      check("vec_done_e4", int'(DONE), int'(vecs[i].last));
      step();
      check("vec_busy_e5", int'(busy), 0);
    end

    // Six back-to-back words with valid held: fills FIFO, WR every 3 cycles
    wait_idle();
    wr_times.delete();
    max_count = 0;
    saw_full = 1'b0;
    d0 = done_pulses;
    send_batch(6, -1, 3, 0, sent);
    check("stream_accept", sent, 6);
    wait_idle();
    check("stream_wr_count", wr_times.size(), 6);
    for (int i = 1; i < wr_times.size(); i++)
      check("stream_wr_spacing", wr_times[i] - wr_times[i-1], 3);
    check("stream_max_count", max_count, DEPTH);
    check("stream_saw_full", int'(saw_full), 1);
    check("stream_no_done", done_pulses - d0, 0);

    // Batch of three, last on the third: one DONE right after its WR
    d0 = done_pulses;
    send_batch(3, 2, 8, 0, sent);
    check("batch_accept", sent, 3);
    wait_idle();
    check("batch_done_pulses", done_pulses - d0, 1);

    // Reset in the middle of WRITE with a second entry queued
    send_batch(2, -1, 9, 0, sent);
    check("rstmid_accept", sent, 2);
    g = 0;
    while (!WR && g < 20) begin
      step();
      g++;
    end
    check("rstmid_reached_write", int'(WR), 1);
    #1;
    rst = 1'b0;
    #1;
    check("rstmid_wr_async", int'(WR), 0);
    check("rstmid_count", int'(count), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_dest", int'(dest), 0);
    exp_q.delete();
    wn = wr_times.size();
    step();
    rst = 1'b1;
    repeat (10) step();
    check("rstmid_no_wr", wr_times.size(), wn);
    check("rstmid_idle", int'(busy), 0);

    // Ten words with random gaps: both pointers wrap twice
    d0 = done_pulses;
    max_count = 0;
    send_batch(10, 9, 2, 4, sent);
    check("wrap_accept", sent, 10);
    wait_idle();
    check("wrap_max_count", int'(max_count <= DEPTH), 1);
    check("wrap_done", done_pulses - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
# dp_sequencer

Instruction sequencer for the 8×32-bit register-bank + K_ALU datapath. Accepts 16-bit register-to-register instructions through a valid/ready handshake, buffers them in a small FIFO and issues each one to the datapath as a fixed three-state read/execute/write sequence. Drives the datapath's `src1`, `src2`, `dest`, `opcode`, `WR` and `DONE` inputs directly, and sits between an instruction source (testbench, ROM walker or host) and `data_path`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CW`, `$clog2(DEPTH)+1`: width of `count`.

- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Low clears all state immediately.
- `instr_in`  in  16  instruction word: [15:12] opcode, [11:9] dest, [8:6] src1, [5:3] src2, [2:1] reserved (ignored), [0] last.
- `instr_valid`  in  1  `instr_in` is valid.
- `instr_ready`  out  1  FIFO can accept; equals `count != DEPTH`.
- `count`  out  CW  current FIFO occupancy, 0..DEPTH.
- `busy`  out  1  high in any state other than IDLE.
- `src1`, `src2`, `dest`  out  3  register addresses to datapath.
- `opcode`  out  4  ALU function select to datapath.
- `WR`  out  1  register-bank write enable, one-cycle pulse per instruction.
- `DONE`  out  1  one-cycle pulse after a batch ends (instruction with last=1).

## Operation
- FIFO: circular buffer, DEPTH entries, read/write pointers wrap modulo DEPTH.
  - Push on `instr_valid && instr_ready` at the rising edge.
  - Pop only in FETCH; FETCH is entered only when `count != 0`, so underflow cannot occur.
  - Simultaneous push and pop: both take effect, `count` unchanged.
  - When full, `instr_ready` is 0 even if a pop occurs in the same cycle (no full-bypass).
- Instruction register IR (16 bits) loaded from FIFO head in FETCH; `src1/src2/dest/opcode` are IR fields and hold their value until the next FETCH.
- FSM states, encoded in a registered state variable; `WR`, `DONE`, `busy` are decoded from state only:
  - IDLE: `count != 0` → FETCH, else stay.
  - FETCH: IR ← head, pop → READ.
  - READ: addresses/opcode stable; register read and ALU settle → WRITE.
  - WRITE: `WR`=1 → FIN if IR.last; else FETCH if `count != 0` (count after this edge's push); else IDLE.
  - FIN: `DONE`=1 → FETCH if `count != 0`, else IDLE.
- `dest`=0 is a normal write; no field is filtered. Reserved bits are ignored.
- Reset (`rst`=0): state=IDLE, pointers=0, `count`=0, IR=0, so all outputs=0 except `instr_ready`=1. Asserting reset mid-sequence discards IR and all queued entries; `WR`/`DONE` fall asynchronously.

## Timing
- Push accepted at edge E0 with FSM idle: FETCH during cycle E1–E2, READ E2–E3, `WR` high E3–E4; the bank captures on E4.
- Back-to-back throughput: one instruction per 3 cycles (FETCH, READ, WRITE); a last=1 instruction adds one FIN cycle.
- Fields on `src1/src2/dest/opcode` are valid for the whole of READ and WRITE (≥2 cycles before the write edge).
- `DONE` is high exactly in the cycle after the `WR` of the last=1 instruction.
- `count` and `instr_ready` update on the push/pop edge. No combinational path runs from `instr_valid` to `instr_ready`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles → `WR`=`DONE`=`busy`=0, `count`=0, `instr_ready`=1, all address/opcode outputs 0.
- Single instruction 16'h1651 pushed at E0 → `WR` high only in cycle E3–E4 with opcode=1, dest=3, src1=1, src2=2. `DONE` high E4–E5. `busy`=0 from E5.
- Hold `instr_valid` high for 6 consecutive words (DEPTH=4, last=0, dest 1..6) → `instr_ready` drops when `count`=4. All 6 are accepted in order. `WR` pulses exactly 3 cycles apart with dest 1,2,…,6. `DONE` never asserts.
- Batch of 3 with last=1 only on the third → exactly one `DONE` pulse, in the cycle after the third `WR`.
- Two entries queued; assert `rst` in the middle of WRITE → `WR` falls immediately and `count`=0. After release, no `WR` occurs until a new push.
- Push 10 instructions spread over pops so both pointers wrap at least twice → issue order equals push order and `count` never exceeds 4 or underflows.
